// File: rtl/cpu_pkg.sv
// Shared constants and the fetch state encoding used by the fetch unit
// and the cpu-side blocks around it.
package cpu_pkg;

  localparam int unsigned INST_W    = 32;
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
  localparam logic [31:0] PC_STEP   = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_e;

endpackage : cpu_pkg

// File: rtl/inst_mem.sv
// Word-addressed memory with one synchronous write port and a
// combinational read port. No reset: contents survive a fetch-unit reset.
module inst_mem #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [0:(1 << ADDR_W)-1];

  // Single write port, no reset on the array.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule : inst_mem

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: loader-programmed instruction memory plus a PC
// that streams one instruction per cycle to the cpu over valid/ready.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | after reset; memory writable, waiting for start
//   ST_FETCH | streaming; memory write-protected, redirects honoured
//   ST_HALT  | halt word reached or illegal PC; memory writable, restartable
module inst_fetch_unit #(
  parameter int unsigned ADDR_W    = 6,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = cpu_pkg::HALT_WORD
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [31:0]       prog_data,
  input  logic              start,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  input  logic              inst_ready,
  output logic [31:0]       inst_out,
  output logic [31:0]       inst_pc,
  output logic              inst_valid,
  output logic              halted,
  output logic              fault,
  output logic              busy
);

  import cpu_pkg::*;

  fetch_state_e      state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [31:0]       inst_pc_q, inst_pc_d;
  logic              valid_q, valid_d;
  logic              halted_q, halted_d;
  logic              fault_q, fault_d;

  logic [INST_W-1:0] rd_word;
  logic              mem_we;
  logic              pc_illegal;

  // Loader writes are locked out while streaming so the running program
  // cannot change under the PC.
  assign mem_we = prog_we && (state_q != ST_FETCH);

  // A PC is illegal if misaligned or if any bit above the memory index is set.
  assign pc_illegal = (pc_q[1:0] != 2'b00) || (|pc_q[31:ADDR_W+2]);

  inst_mem #(
    .ADDR_W (ADDR_W),
    .DATA_W (INST_W)
  ) u_inst_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (prog_addr),
    .wdata_i (prog_data),
    .raddr_i (pc_q[ADDR_W+1:2]),
    .rdata_o (rd_word)
  );

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      inst_q    <= '0;
      inst_pc_q <= '0;
      valid_q   <= 1'b0;
      halted_q  <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      valid_q   <= valid_d;
      halted_q  <= halted_d;
      fault_q   <= fault_d;
    end
  end

  // Next-state: start handling, then redirect > fetch step > stall in FETCH.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    valid_d   = valid_q;
    halted_d  = halted_q;
    fault_d   = fault_q;

    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          state_d  = ST_FETCH;
          pc_d     = RESET_PC;
          halted_d = 1'b0;
          fault_d  = 1'b0;
          valid_d  = 1'b0;
        end
      end

      ST_FETCH: begin
        if (redirect_valid) begin
          // Flush whatever is in the output slot; target shows up next cycle.
          valid_d = 1'b0;
          pc_d    = redirect_pc;
        end else if (!valid_q || inst_ready) begin
          if (pc_illegal) begin
            fault_d = 1'b0 | 1'b1;
            valid_d = 1'b0;
            state_d = ST_HALT;
          end else if (rd_word == HALT_WORD) begin
            // PC stays on the halt word so it can be inspected afterwards.
            valid_d  = 1'b0;
            halted_d = 1'b1;
            state_d  = ST_HALT;
          end else begin
            inst_d    = rd_word;
            inst_pc_d = pc_q;
            valid_d   = 1'b1;
            pc_d      = pc_q + PC_STEP;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign inst_out   = inst_q;
  assign inst_pc    = inst_pc_q;
  assign inst_valid = valid_q;
  assign halted     = halted_q;
  assign fault      = fault_q;
  assign busy       = (state_q == ST_FETCH);

endmodule : inst_fetch_unit

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: straight-line streaming, stall,
// redirect, illegal-PC faults, reset mid-fetch and loader lockout.
module tb_inst_fetch_unit;

  localparam logic [31:0] HALT_W = 32'hFFFF_FFFF;
  localparam logic [31:0] ADDI1  = 32'h2001_0001;
  localparam logic [31:0] ADDI2  = 32'h2002_0001;

  logic        clk;
  logic        reset;
  logic        prog_we;
  logic [5:0]  prog_addr;
  logic [31:0] prog_data;
  logic        start;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        halted;
  logic        fault;
  logic        busy;

  int errors = 0;
  int checks = 0;

  inst_fetch_unit #(
    .ADDR_W    (6),
    .RESET_PC  (32'h0000_0000),
    .HALT_WORD (32'hFFFF_FFFF)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .prog_we        (prog_we),
    .prog_addr      (prog_addr),
    .prog_data      (prog_data),
    .start          (start),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_ready     (inst_ready),
    .inst_out       (inst_out),
    .inst_pc        (inst_pc),
    .inst_valid     (inst_valid),
    .halted         (halted),
    .fault          (fault),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // add $i,$0,$0 style words for the 8-word program
  function automatic logic [31:0] prog8(input int i);
    logic [31:0] w;
    w = 32'h0000_0020 | (32'(i) << 11);
    return w;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic load_word(input logic [5:0] a, input logic [31:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_to_halt(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick();
      ok = (halted === 1'b1) || (fault === 1'b1);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    checks++; if (inst_out !== 32'h0) begin errors++; $display("FAIL reset_inst_out: got %h want 00000000", inst_out); end
    checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL reset_inst_pc: got %h want 00000000", inst_pc); end
    checks++; if ({inst_valid, halted, fault, busy} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got v/h/f/b=%b want 0000", {inst_valid, halted, fault, busy}); end
    reset = 1'b0;
  endtask

  task automatic test_straight();
    int n_valid;
    logic [31:0] pc_seen [2];
    logic [31:0] op_seen [2];
    bit done;
    load_word(6'd0, ADDI1);
    load_word(6'd1, ADDI2);
    load_word(6'd2, HALT_W);
    inst_ready = 1'b1;
    pulse_start();
    checks++; if ({busy, inst_valid} !== 2'b10) begin errors++; $display("FAIL straight_first_cycle: got busy/valid=%b want 10", {busy, inst_valid}); end
    n_valid = 0; done = 1'b0;
    pc_seen[0] = 'x; pc_seen[1] = 'x; op_seen[0] = 'x; op_seen[1] = 'x;
    for (int i = 0; i < 20 && !done; i++) begin
      tick();
      if (inst_valid === 1'b1) begin
        if (n_valid < 2) begin pc_seen[n_valid] = inst_pc; op_seen[n_valid] = inst_out; end
        n_valid++;
      end
      if (halted === 1'b1) done = 1'b1;
    end
    checks++; if (!done) begin errors++; $display("FAIL straight_timeout: halted=%b want 1 within 20 cycles", halted); end
    checks++; if (n_valid !== 2) begin errors++; $display("FAIL straight_valid_count: got %0d want 2", n_valid); end
    checks++; if (pc_seen[0] !== 32'h0 || op_seen[0] !== ADDI1) begin errors++; $display("FAIL straight_word0: got pc=%h inst=%h want 00000000 %h", pc_seen[0], op_seen[0], ADDI1); end
    checks++; if (pc_seen[1] !== 32'h4 || op_seen[1] !== ADDI2) begin errors++; $display("FAIL straight_word1: got pc=%h inst=%h want 00000004 %h", pc_seen[1], op_seen[1], ADDI2); end
    checks++; if ({halted, fault, busy, inst_valid} !== 4'b1000) begin errors++; $display("FAIL straight_end_flags: got h/f/b/v=%b want 1000", {halted, fault, busy, inst_valid}); end
  endtask

  task automatic test_stall();
    bit ok;
    inst_ready = 1'b0;
    pulse_start();
    tick();
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst_out !== ADDI1) begin errors++; $display("FAIL stall_first: got v=%b pc=%h inst=%h want 1 00000000 %h", inst_valid, inst_pc, inst_out, ADDI1); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst_out !== ADDI1) begin errors++; $display("FAIL stall_hold%0d: got v=%b pc=%h inst=%h want 1 00000000 %h", i, inst_valid, inst_pc, inst_out, ADDI1); end
    end
    inst_ready = 1'b1;
    tick();
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h4 || inst_out !== ADDI2) begin errors++; $display("FAIL stall_release: got v=%b pc=%h inst=%h want 1 00000004 %h", inst_valid, inst_pc, inst_out, ADDI2); end
    run_to_halt(ok);
    checks++; if (!ok || halted !== 1'b1) begin errors++; $display("FAIL stall_halt: got halted=%b want 1", halted); end
  endtask

  task automatic test_redirect();
    bit ok;
    for (int i = 0; i < 8; i++) load_word(6'(i), prog8(i));
    load_word(6'd8, HALT_W);
    inst_ready = 1'b1;
    pulse_start();
    tick();
    tick();
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h4 || inst_out !== prog8(1)) begin errors++; $display("FAIL redir_pre: got v=%b pc=%h inst=%h want 1 00000004 %h", inst_valid, inst_pc, inst_out, prog8(1)); end
    redirect_valid = 1'b1; redirect_pc = 32'h14;
    tick();
    redirect_valid = 1'b0;
    checks++; if (inst_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL redir_flush: got v=%b busy=%b want 0 1", inst_valid, busy); end
    tick();
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h14 || inst_out !== prog8(5)) begin errors++; $display("FAIL redir_target: got v=%b pc=%h inst=%h want 1 00000014 %h", inst_valid, inst_pc, inst_out, prog8(5)); end
    run_to_halt(ok);
    checks++; if (!ok || halted !== 1'b1 || fault !== 1'b0) begin errors++; $display("FAIL redir_halt: got halted=%b fault=%b want 1 0", halted, fault); end
  endtask

  task automatic test_fault(input logic [31:0] target, input string name);
    pulse_start();
    tick();
    redirect_valid = 1'b1; redirect_pc = target;
    tick();
    redirect_valid = 1'b0;
    checks++; if (fault !== 1'b0 || busy !== 1'b1 || inst_valid !== 1'b0) begin errors++; $display("FAIL %s_pending: got f=%b b=%b v=%b want 0 1 0", name, fault, busy, inst_valid); end
    tick();
    checks++; if ({fault, halted, inst_valid, busy} !== 4'b1000) begin errors++; $display("FAIL %s: got f/h/v/b=%b want 1000", name, {fault, halted, inst_valid, busy}); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    pulse_start();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if ({inst_valid, halted, fault, busy} !== 4'b0000 || inst_out !== 32'h0 || inst_pc !== 32'h0) begin errors++; $display("FAIL rstmid_outputs: got v/h/f/b=%b inst=%h pc=%h want 0000 0 0", {inst_valid, halted, fault, busy}, inst_out, inst_pc); end
    tick();
    checks++; if (busy !== 1'b0 || inst_valid !== 1'b0) begin errors++; $display("FAIL rstmid_idle: got busy=%b v=%b want 0 0", busy, inst_valid); end
    pulse_start();
    tick();
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst_out !== prog8(0)) begin errors++; $display("FAIL rstmid_retained: got v=%b pc=%h inst=%h want 1 00000000 %h", inst_valid, inst_pc, inst_out, prog8(0)); end
    run_to_halt(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_halt: got halted=%b want 1", halted); end
  endtask

  task automatic test_lockout();
    bit ok;
    pulse_start();
    prog_we = 1'b1; prog_addr = 6'd1; prog_data = 32'hDEAD_BEEF;
    tick();
    prog_we = 1'b0;
    tick();
    checks++; if (inst_pc !== 32'h4 || inst_out !== prog8(1)) begin errors++; $display("FAIL lockout_fetch: got pc=%h inst=%h want 00000004 %h", inst_pc, inst_out, prog8(1)); end
    run_to_halt(ok);
    load_word(6'd1, 32'h1234_5678);
    pulse_start();
    tick();
    tick();
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h4 || inst_out !== 32'h1234_5678) begin errors++; $display("FAIL lockout_halt_write: got v=%b pc=%h inst=%h want 1 00000004 12345678", inst_valid, inst_pc, inst_out); end
    run_to_halt(ok);
    checks++; if (!ok) begin errors++; $display("FAIL lockout_halt: got halted=%b want 1", halted); end
  endtask

  task automatic test_write_with_start();
    bit ok;
    prog_we = 1'b1; prog_addr = 6'd0; prog_data = 32'h2003_0005;
    start = 1'b1;
    tick();
    prog_we = 1'b0; start = 1'b0;
    tick();
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst_out !== 32'h2003_0005) begin errors++; $display("FAIL write_start: got v=%b pc=%h inst=%h want 1 00000000 20030005", inst_valid, inst_pc, inst_out); end
    run_to_halt(ok);
    checks++; if (!ok) begin errors++; $display("FAIL write_start_halt: got halted=%b want 1", halted); end
  endtask

  initial begin
    reset = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    start = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b1;
    tick();
    test_reset();
    test_straight();
    test_stall();
    test_redirect();
    test_fault(32'h0000_0102, "fault_misaligned");
    test_fault(32'h0000_0100, "fault_range");
    test_reset_mid();
    test_lockout();
    test_write_with_start();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_inst_fetch_unit

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Upstream neighbour of cpu. Holds a word-addressed instruction memory and a program counter, and presents one 32-bit instruction per cycle on a valid/ready handshake to the cpu's instruction input.
- Supports bench/loader programming, start/halt control, branch redirect from the cpu, and fault on an illegal PC.
- Replaces hand-driving of Inst in testbenches: a program is loaded, then the unit streams it.

Parameters:
- ADDR_W, 6, log2 of instruction memory depth in words (64 words).
- RESET_PC, 32'h0000_0000, PC loaded on reset and on start.
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding that stops fetch; never presented to the cpu.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- prog_we  in  1  write enable for instruction memory (loader).
- prog_addr  in  ADDR_W  word index to write.
- prog_data  in  32  instruction word to write.
- start  in  1  one-cycle pulse; begin fetching at RESET_PC.
- redirect_valid  in  1  cpu requests a PC change (branch/jump taken).
- redirect_pc  in  32  target byte address.
- inst_ready  in  1  cpu accepts inst_out this cycle.
- inst_out  out  32  instruction to cpu (cpu's Inst).
- inst_pc  out  32  byte address of inst_out.
- inst_valid  out  1  inst_out/inst_pc are meaningful.
- halted  out  1  HALT_WORD reached.
- fault  out  1  illegal PC (misaligned or beyond memory).
- busy  out  1  state == FETCH.

Behaviour:
- Reset: state=IDLE, pc=RESET_PC, inst_out=0, inst_pc=0, inst_valid=0, halted=0, fault=0, busy=0. Memory contents are not cleared. Reset mid-FETCH returns to IDLE immediately and drops inst_valid.
- States: IDLE, FETCH, HALT.
  - IDLE/HALT + start: go to FETCH, pc=RESET_PC, halted=0, fault=0, inst_valid=0.
  - FETCH + HALT_WORD read: go to HALT.
  - FETCH + illegal PC: go to HALT.
- Programming: prog_we writes mem[prog_addr]=prog_data only in IDLE or HALT; ignored in FETCH. A write and a start in the same cycle: the write lands, and fetch begins next cycle, so the first fetch sees the new data.
- Fetch step: in FETCH, when the output slot is free (!inst_valid || inst_ready) and there is no redirect, read mem[pc[ADDR_W+1:2]]:
  - Normal word: inst_out<=word, inst_pc<=pc, inst_valid<=1, pc<=pc+4 (32-bit wrap).
  - HALT_WORD: inst_valid<=0, halted<=1, state<=HALT, pc frozen at the halt address.
- Latency: 1 cycle from PC to inst_valid. Sustained throughput is 1 instruction/cycle with inst_ready held high.
- Stall: inst_valid && !inst_ready holds inst_out, inst_pc and pc stable.
- Redirect: in FETCH, redirect_valid has priority over the fetch step and the stall. It sets inst_valid<=0 (the in-flight instruction is flushed) and pc<=redirect_pc. The target instruction appears the following cycle. redirect_valid outside FETCH is ignored.
- Illegal PC: pc[1:0]!=0 or pc[31:ADDR_W+2]!=0 at a fetch step sets fault<=1, inst_valid<=0, state<=HALT. halted stays 0.
- start while in FETCH is ignored.

Decomposition:
- Shared package cpu_pkg: INST_W=32, HALT_WORD, fetch state encoding (IDLE/FETCH/HALT), PC_STEP=4.
- One natural sub-module: inst_mem, a single write port, combinational read, no reset. It is reusable for a later data memory.

Test Plan:
- Straight-line: load addi $1,$0,1 (0x20010001) at 0, addi $2,$0,1 at 1, HALT_WORD at 2; pulse start with inst_ready=1 -> inst_valid for exactly 2 cycles, inst_pc=0 then 4; then halted=1, fault=0, busy=0.
- Stall: same program with inst_ready=0 for 3 cycles after the first valid -> inst_out stays 0x20010001, inst_pc stays 0; the second word follows one cycle after inst_ready rises.
- Redirect: 8-word program of adds; assert redirect_valid with redirect_pc=0x14 while inst_pc=0x4 is valid -> next cycle inst_valid=0; the cycle after, inst_pc=0x14.
- Faults: redirect_pc=0x102 -> fault=1, halted=0, inst_valid=0. Separately, redirect_pc=0x100 with ADDR_W=6 -> fault=1.
- Reset mid-fetch: assert reset during FETCH -> next cycle all outputs at reset values and state IDLE. Memory retained: start re-streams the same program from 0.
- Programming lockout: prog_we to word 1 during FETCH is ignored (old word is fetched); the same write in HALT takes effect, confirmed on restart.
